// File: rtl/gpio_link_ctrl.sv
// Inter-board GPIO button link: 4-phase req/ack TX of local buttons, RX capture of peer buttons,
// and an ack-timeout supervisor that drives link_ok. RX latency is 3 clk edges from the peer req pin.
module gpio_link_ctrl #(
  parameter int SETUP_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m_left,
  input  logic       m_right,
  output logic [1:0] gpio_tx_data,
  output logic       gpio_tx_req,
  input  logic       gpio_rx_ack,
  input  logic [1:0] gpio_rx_data,
  input  logic       gpio_rx_req,
  output logic       gpio_tx_ack,
  output logic       remote_left,
  output logic       remote_right,
  output logic       link_ok,
  output logic       tx_busy
);

  localparam int SW = $clog2(SETUP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    T_INIT,
    T_IDLE,
    T_SETUP,
    T_REQ,
    T_REL
  } tx_state_t;

  typedef enum logic {
    R_IDLE,
    R_ACK
  } rx_state_t;

  tx_state_t     tx_state;
  rx_state_t     rx_state;
  logic [1:0]    last_sent;
  logic [SW-1:0] setup_cnt;
  logic [TW-1:0] to_cnt;

  logic [1:0]    ack_sync;
  logic [1:0]    req_sync;
  logic [1:0]    data_meta;
  logic [1:0]    data_s;
  logic          ack_s;
  logic          req_s;
  logic [1:0]    btn;

  assign ack_s = ack_sync[1];
  assign req_s = req_sync[1];
  assign btn   = {m_right, m_left};

  // Peer signals are asynchronous; only the second-stage copies feed decisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_sync  <= 2'b00;
      req_sync  <= 2'b00;
      data_meta <= 2'b00;
      data_s    <= 2'b00;
    end else begin
      ack_sync  <= {ack_sync[0], gpio_rx_ack};
      req_sync  <= {req_sync[0], gpio_rx_req};
      data_meta <= gpio_rx_data;
      data_s    <= data_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state     <= T_INIT;
      gpio_tx_data <= 2'b00;
      gpio_tx_req  <= 1'b0;
      last_sent    <= 2'b00;
      setup_cnt    <= '0;
      to_cnt       <= '0;
      link_ok      <= 1'b0;
      tx_busy      <= 1'b0;
    end else begin
      case (tx_state)
        T_INIT: begin
          // Unconditional first transfer so both boards agree on state after reset.
          gpio_tx_data <= btn;
          setup_cnt    <= '0;
          tx_busy      <= 1'b1;
          tx_state     <= T_SETUP;
        end
        T_IDLE: begin
          if (btn != last_sent) begin
            gpio_tx_data <= btn;
            setup_cnt    <= '0;
            tx_busy      <= 1'b1;
            tx_state     <= T_SETUP;
          end
        end
        T_SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            gpio_tx_req <= 1'b1;
            to_cnt      <= '0;
            tx_state    <= T_REQ;
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        T_REQ: begin
          if (ack_s) begin
            gpio_tx_req <= 1'b0;
            to_cnt      <= '0;
            tx_state    <= T_REL;
          end else if (to_cnt == TO_LAST) begin
            link_ok <= 1'b0;
            to_cnt  <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        T_REL: begin
          if (!ack_s) begin
            last_sent <= gpio_tx_data;
            link_ok   <= 1'b1;
            to_cnt    <= '0;
            tx_busy   <= 1'b0;
            tx_state  <= T_IDLE;
          end else if (to_cnt == TO_LAST) begin
            link_ok <= 1'b0;
            to_cnt  <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: begin
          gpio_tx_req <= 1'b0;
          tx_busy     <= 1'b0;
          tx_state    <= T_INIT;
        end
      endcase
    end
  end

  // RX is independent of TX; a stuck peer req simply holds our ack high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state     <= R_IDLE;
      gpio_tx_ack  <= 1'b0;
      remote_left  <= 1'b0;
      remote_right <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (req_s) begin
            remote_right <= data_s[1];
            remote_left  <= data_s[0];
            gpio_tx_ack  <= 1'b1;
            rx_state     <= R_ACK;
          end
        end
        R_ACK: begin
          if (!req_s) begin
            gpio_tx_ack <= 1'b0;
            rx_state    <= R_IDLE;
          end
        end
        default: begin
          gpio_tx_ack <= 1'b0;
          rx_state    <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_link_ctrl.sv
// Two cross-connected link controllers with a scoreboard of expected peer button values.
module tb_gpio_link_ctrl;

  localparam int SETUP = 2;
  localparam int TOUT  = 16;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic a_m_left, a_m_right, b_m_left, b_m_right;
  logic [1:0] a_tx_data, b_tx_data;
  logic a_tx_req, b_tx_req, a_tx_ack, b_tx_ack;
  logic a_rx_ack;
  logic a_remote_left, a_remote_right, b_remote_left, b_remote_right;
  logic a_link_ok, b_link_ok, a_tx_busy, b_tx_busy;
  logic ack_block;

  int checks = 0;
  int failures = 0;
  int a_req_rises = 0;
  logic [1:0] qa[$];
  logic [1:0] qb[$];

  always #5 clk = ~clk;

  assign a_rx_ack = ack_block ? 1'b0 : b_tx_ack;

  gpio_link_ctrl #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TOUT)) u_a (
    .clk(clk), .rst(rst_a), .m_left(a_m_left), .m_right(a_m_right),
    .gpio_tx_data(a_tx_data), .gpio_tx_req(a_tx_req), .gpio_rx_ack(a_rx_ack),
    .gpio_rx_data(b_tx_data), .gpio_rx_req(b_tx_req), .gpio_tx_ack(a_tx_ack),
    .remote_left(a_remote_left), .remote_right(a_remote_right),
    .link_ok(a_link_ok), .tx_busy(a_tx_busy)
  );

  gpio_link_ctrl #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TOUT)) u_b (
    .clk(clk), .rst(rst_b), .m_left(b_m_left), .m_right(b_m_right),
    .gpio_tx_data(b_tx_data), .gpio_tx_req(b_tx_req), .gpio_rx_ack(b_tx_ack),
    .gpio_rx_data(a_tx_data), .gpio_rx_req(a_tx_req), .gpio_tx_ack(b_tx_ack),
    .remote_left(b_remote_left), .remote_right(b_remote_right),
    .link_ok(b_link_ok), .tx_busy(b_tx_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 200 && !done; i++) begin
      if (!a_tx_busy && !b_tx_busy) done = 1'b1;
      else tick();
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic wait_a_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (a_tx_req) seen = 1'b1;
      else tick();
    end
    chk(tag, seen, 1'b1);
  endtask

  // Scoreboard: every rising receiver ack must deliver the next expected button pair.
  logic prev_a_ack = 1'b0, prev_b_ack = 1'b0, prev_a_req = 1'b0;
  always @(negedge clk) begin
    if (b_tx_ack && !prev_b_ack) begin
      chk("sb_b_nonempty", qb.size() != 0, 1'b1);
      if (qb.size() != 0) chk("sb_b_remote", {b_remote_right, b_remote_left}, qb.pop_front());
    end
    if (a_tx_ack && !prev_a_ack) begin
      chk("sb_a_nonempty", qa.size() != 0, 1'b1);
      if (qa.size() != 0) chk("sb_a_remote", {a_remote_right, a_remote_left}, qa.pop_front());
    end
    if (a_tx_req && !prev_a_req) a_req_rises++;
    prev_a_ack = a_tx_ack;
    prev_b_ack = b_tx_ack;
    prev_a_req = a_tx_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises0;
    rst_a = 1'b1; rst_b = 1'b1; ack_block = 1'b0;
    a_m_left = 1'b0; a_m_right = 1'b0; b_m_left = 1'b0; b_m_right = 1'b0;
    repeat (3) tick();
    chk("reset_a_outs", {a_tx_data, a_tx_req, a_tx_ack, a_remote_left, a_remote_right, a_link_ok, a_tx_busy}, 8'h00);
    chk("reset_b_outs", {b_tx_data, b_tx_req, b_tx_ack, b_remote_left, b_remote_right, b_link_ok, b_tx_busy}, 8'h00);

    // Reset release: forced init transfer of 00 in both directions.
    qa.push_back(2'b00);
    qb.push_back(2'b00);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    chk("init_busy_a", a_tx_busy, 1'b1);
    chk("init_busy_b", b_tx_busy, 1'b1);
    chk("init_link_low", a_link_ok, 1'b0);
    wait_idle("init_idle");
    chk("init_link_a", a_link_ok, 1'b1);
    chk("init_link_b", b_link_ok, 1'b1);
    chk("init_remote_b", {b_remote_right, b_remote_left}, 2'b00);

    // Single left-button press with exact handshake timing.
    a_m_left = 1'b1;
    qb.push_back(2'b01);
    tick();
    chk("a_data_n1", a_tx_data, 2'b01);
    chk("a_req_n1", a_tx_req, 1'b0);
    tick();
    chk("a_req_n2", a_tx_req, 1'b0);
    tick();
    chk("a_req_n3", a_tx_req, 1'b1);
    tick(); tick();
    chk("b_ack_n5", b_tx_ack, 1'b0);
    tick();
    chk("b_ack_n6", b_tx_ack, 1'b1);
    chk("b_left_n6", b_remote_left, 1'b1);
    wait_idle("press_idle");
    chk("press_link", a_link_ok, 1'b1);

    // Left toggles inside a transaction started by right: no extra transfer.
    rises0 = a_req_rises;
    a_m_right = 1'b1;
    qb.push_back(2'b11);
    tick();
    chk("tog_data", a_tx_data, 2'b11);
    a_m_left = 1'b0;
    tick();
    a_m_left = 1'b1;
    tick();
    chk("tog_data_held", a_tx_data, 2'b11);
    wait_idle("tog_idle");
    repeat (20) tick();
    chk("tog_still_idle", a_tx_busy, 1'b0);
    chk("tog_single_req", a_req_rises - rises0, 1);
    chk("tog_remote", {b_remote_right, b_remote_left}, 2'b11);

    // Simultaneous change on both boards.
    a_m_left = 1'b0;
    b_m_left = 1'b1;
    qb.push_back(2'b10);
    qa.push_back(2'b01);
    wait_idle("simul_idle");
    chk("simul_remote_a", {a_remote_right, a_remote_left}, 2'b01);
    chk("simul_remote_b", {b_remote_right, b_remote_left}, 2'b10);
    chk("simul_links", {a_link_ok, b_link_ok}, 2'b11);

    // Ack path cut: link_ok must drop exactly TOUT cycles after req rises.
    ack_block = 1'b1;
    a_m_left = 1'b1;
    qb.push_back(2'b11);
    tick();
    wait_a_req("to_req_seen");
    repeat (TOUT - 1) tick();
    chk("to_link_before", a_link_ok, 1'b1);
    tick();
    chk("to_link_after", a_link_ok, 1'b0);
    chk("to_req_held", a_tx_req, 1'b1);
    repeat (5) tick();
    chk("to_busy_held", a_tx_busy, 1'b1);
    ack_block = 1'b0;
    wait_idle("to_recover_idle");
    chk("to_recover_link", a_link_ok, 1'b1);

    // Reset A while it waits in T_REQ.
    a_m_left = 1'b0;
    qb.push_back(2'b10);
    tick();
    wait_a_req("rst_req_seen");
    repeat (4) tick();
    #1 rst_a = 1'b1;
    #1;
    chk("rst_async_outs", {a_tx_data, a_tx_req, a_tx_ack, a_remote_left, a_remote_right, a_link_ok, a_tx_busy}, 8'h00);
    repeat (6) tick();
    chk("rst_b_ack_released", b_tx_ack, 1'b0);
    qb.push_back(2'b10);
    rst_a = 1'b0;
    tick();
    chk("rst_reinit_busy", a_tx_busy, 1'b1);
    chk("rst_reinit_data", a_tx_data, 2'b10);
    wait_idle("rst_idle");
    chk("rst_link_recovered", a_link_ok, 1'b1);
    chk("rst_b_ack_idle", b_tx_ack, 1'b0);

    repeat (5) tick();
    chk("sb_a_drained", qa.size(), 0);
    chk("sb_b_drained", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
